// File: rtl/store_unit.sv
// store_unit -- store queue between the MEM stage and data memory.
//
// Stores presented by the MEM stage are decoded into a word address,
// lane-aligned write data and byte enables, then buffered in a FIFO of
// DEPTH entries. The head entry is presented to data memory with a
// valid/ready handshake. Misaligned stores and illegal widths are
// dropped and reported with a one-cycle st_err pulse.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  MEM stage presents a store this cycle
//   req_ready  a store can be accepted this cycle (count < DEPTH)
//   funct3     store width: 000 SB, 001 SH, 010 SW, others illegal
//   addr       byte address of the store
//   wdata_in   rs2 value; the low byte/half/word is stored
//   mem_valid  head entry presented to data memory
//   mem_ready  data memory accepts the head this cycle
//   mem_addr   word address of the head (0 when empty)
//   mem_wdata  lane-aligned write data of the head (0 when empty)
//   mem_be     byte enables of the head, bit i = lane i (0 when empty)
//   st_err     one-cycle pulse after a rejected store
//   empty      queue holds no entries

module store_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_in,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        st_err,
  output logic        empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Queue storage: word address, lane-aligned data and byte enables.
  logic [29:0] waddr_q [DEPTH];
  logic [31:0] wdata_q [DEPTH];
  logic [3:0]  be_q    [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Decoded form of the incoming store.
  logic        legal;
  logic [3:0]  dec_be;
  logic [31:0] dec_wdata;

  logic accept;
  logic push;
  logic pop;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    legal     = 1'b0;
    dec_be    = 4'b0000;
    dec_wdata = 32'h0;
    case (funct3)
      3'b000: begin
        legal     = 1'b1;
        dec_be    = 4'b0001 << addr[1:0];
        dec_wdata = {4{wdata_in[7:0]}};
      end
      3'b001: begin
        legal     = ~addr[0];
        dec_be    = addr[1] ? 4'b1100 : 4'b0011;
        dec_wdata = {2{wdata_in[15:0]}};
      end
      3'b010: begin
        legal     = (addr[1:0] == 2'b00);
        dec_be    = 4'b1111;
        dec_wdata = wdata_in;
      end
      default: ;
    endcase
  end

  // Acceptance depends only on occupancy: a full queue stalls the MEM
  // stage even if memory drains the head on the same edge.
  assign req_ready = (count < CNT_W'(DEPTH));
  assign accept    = req_valid && req_ready && !rst;
  assign push      = accept && legal;
  assign mem_valid = (count != '0);
  assign pop       = mem_valid && mem_ready;
  assign empty     = (count == '0);

  // Head fields come straight from storage, forced to zero when empty so
  // stale entries are never visible.
  assign mem_addr  = mem_valid ? {waddr_q[rd_ptr], 2'b00} : 32'h0;
  assign mem_wdata = mem_valid ? wdata_q[rd_ptr] : 32'h0;
  assign mem_be    = mem_valid ? be_q[rd_ptr] : 4'b0000;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      st_err <= 1'b0;
    end else begin
      st_err <= accept && !legal;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: entry storage is deliberately not reset; clearing count makes
  // every entry invalid, and the output mux hides contents while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      waddr_q[wr_ptr] <= addr[31:2];
      wdata_q[wr_ptr] <= dec_wdata;
      be_q[wr_ptr]    <= dec_be;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
module tb_store_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata_in;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        st_err;
  logic        empty;

  store_unit #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .funct3    (funct3),
    .addr      (addr),
    .wdata_in  (wdata_in),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .st_err    (st_err),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [3:0]  be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_addr;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: an ordered list of pending memory writes.
  entry_t q[$];
  bit     err_exp  = 1'b0;
  bit     model_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A store of n bytes is legal when n is 1/2/4 and addr is a multiple of n.
  // It covers lanes addr%4 .. addr%4+n-1; lane i carries byte (i mod n) of
  // the source, which yields the replication pattern for SB/SH.
  function automatic void ref_store(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] d, output bit legal,
                                    output entry_t e);
    int n;
    int off;
    n   = 1 << f3;
    off = int'(a[1:0]);
    legal = (f3 < 3) && ((a % n) == 0);
    e.addr  = a & 32'hFFFF_FFFC;
    e.be    = 4'b0000;
    e.wdata = 32'h0;
    if (legal) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + n) e.be[i] = 1'b1;
        e.wdata[8*i +: 8] = d[8*(i % n) +: 8];
      end
    end
  endfunction

  task automatic compare_model();
    check("req_ready", req_ready, q.size() < DEPTH);
    check("mem_valid", mem_valid, q.size() != 0);
    check("empty", empty, q.size() == 0);
    check("st_err", st_err, err_exp);
    if (q.size() != 0) begin
      check("mem_addr", mem_addr, q[0].addr);
      check("mem_wdata", mem_wdata, q[0].wdata);
      check("mem_be", mem_be, q[0].be);
    end else begin
      check("mem_addr idle", mem_addr, 32'h0);
      check("mem_wdata idle", mem_wdata, 32'h0);
      check("mem_be idle", mem_be, 4'h0);
    end
  endtask

  task automatic model_update();
    bit     acc;
    bit     pop_m;
    bit     legal;
    entry_t e;
    if (rst) begin
      q.delete();
      err_exp = 1'b0;
    end else begin
      acc   = req_valid && (q.size() < DEPTH);
      pop_m = (q.size() != 0) && mem_ready;
      ref_store(funct3, addr, wdata_in, legal, e);
      if (pop_m) void'(q.pop_front());
      if (acc && legal) q.push_back(e);
      err_exp = acc && !legal;
    end
  endtask

  // One clock: check outputs mid-cycle, advance the model, cross the edge.
  task automatic step();
    @(negedge clk);
    if (model_on) begin
      compare_model();
      model_update();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    funct3    = f3;
    addr      = a;
    wdata_in  = d;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{3'b000, 32'h0000_1003, 32'hAABB_CC5A, 1'b0, 4'b1000, 32'h5A5A_5A5A, 32'h0000_1000};
    vecs[1] = '{3'b001, 32'h0000_2002, 32'h1234_BEEF, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0000_2000};
    vecs[2] = '{3'b001, 32'h0000_2001, 32'h1234_BEEF, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[3] = '{3'b010, 32'h0000_0030, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0030};
    vecs[4] = '{3'b000, 32'h0000_0041, 32'h1234_5678, 1'b0, 4'b0010, 32'h7878_7878, 32'h0000_0040};
    vecs[5] = '{3'b001, 32'h0000_0050, 32'hCAFE_F00D, 1'b0, 4'b0011, 32'hF00D_F00D, 32'h0000_0050};
    vecs[6] = '{3'b011, 32'h0000_0000, 32'h1111_1111, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[7] = '{3'b010, 32'h0000_0002, 32'h2222_2222, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[8] = '{3'b100, 32'h0000_0000, 32'h3333_3333, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[9] = '{3'b000, 32'hFFFF_FFFE, 32'h0000_00A5, 1'b0, 4'b0100, 32'hA5A5_A5A5, 32'hFFFF_FFFC};

    rst = 1'b1; req_valid = 1'b0; funct3 = 3'b000; addr = 32'h0;
    wdata_in = 32'h0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Post-reset state.
    check("reset req_ready", req_ready, 1);
    check("reset mem_valid", mem_valid, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset mem_wdata", mem_wdata, 0);
    check("reset mem_be", mem_be, 0);
    check("reset st_err", st_err, 0);
    check("reset empty", empty, 1);
    model_on = 1'b1;

    // Table-driven single stores, memory always ready.
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_store(vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      step();
      req_valid = 1'b0;
      check($sformatf("vec%0d st_err", i), st_err, vecs[i].err);
      check($sformatf("vec%0d mem_valid", i), mem_valid, !vecs[i].err);
      check($sformatf("vec%0d mem_be", i), mem_be, vecs[i].be);
      check($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
      check($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].exp_addr);
      step();
      check($sformatf("vec%0d empty after", i), empty, 1);
      check($sformatf("vec%0d st_err cleared", i), st_err, 0);
    end

    // Back-to-back SW with memory stalled: third store waits for space.
    mem_ready = 1'b0;
    drive_store(3'b010, 32'h10, 32'hA0A0_0010); step();
    drive_store(3'b010, 32'h14, 32'hA0A0_0014); step();
    drive_store(3'b010, 32'h18, 32'hA0A0_0018);
    check("full req_ready", req_ready, 0);
    step(); step();
    check("stall head addr", mem_addr, 32'h10);
    check("stall head data", mem_wdata, 32'hA0A0_0010);
    mem_ready = 1'b1;
    step();
    check("order 2nd", mem_addr, 32'h14);
    step();
    check("order 3rd", mem_addr, 32'h18);
    req_valid = 1'b0;
    step();
    check("order drained", empty, 1);

    // count=1 with simultaneous push and pop, repeated to wrap pointers.
    mem_ready = 1'b0;
    drive_store(3'b010, 32'h100, 32'h0000_0100); step();
    mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_store(3'b010, 32'h104 + 32'(4 * k), 32'h0000_0104 + 32'(4 * k));
      step();
      check($sformatf("pp%0d head", k), mem_addr, 32'h104 + 32'(4 * k));
      check($sformatf("pp%0d count1 ready", k), req_ready, 1);
      check($sformatf("pp%0d count1 valid", k), mem_valid, 1);
    end
    req_valid = 1'b0;
    step();
    check("pp drained", empty, 1);

    // Reset while full and stalled; the store presented during reset is ignored.
    mem_ready = 1'b0;
    drive_store(3'b010, 32'h200, 32'h0000_0200); step();
    drive_store(3'b010, 32'h204, 32'h0000_0204); step();
    check("pre-rst full", req_ready, 0);
    rst = 1'b1;
    drive_store(3'b010, 32'h208, 32'h0000_0208);
    step();
    rst = 1'b0;
    req_valid = 1'b0;
    check("rst mem_valid", mem_valid, 0);
    check("rst empty", empty, 1);
    check("rst req_ready", req_ready, 1);
    check("rst mem_addr", mem_addr, 0);
    mem_ready = 1'b1;
    repeat (3) step();

    // Rejected store coinciding with a pop.
    mem_ready = 1'b0;
    drive_store(3'b010, 32'h300, 32'h0000_0300); step();
    mem_ready = 1'b1;
    drive_store(3'b001, 32'h303, 32'h0000_0303); step();
    req_valid = 1'b0;
    check("rej+pop st_err", st_err, 1);
    check("rej+pop empty", empty, 1);
    step();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      req_valid = ($urandom_range(0, 9) < 7);
      mem_ready = ($urandom_range(0, 1) == 1);
      funct3    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7))
                                              : 3'($urandom_range(0, 3));
      addr      = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      wdata_in  = $urandom;
      step();
    end
    rst = 1'b0;
    req_valid = 1'b0;
    mem_ready = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
